// File: rtl/digit_ascii_tx_pkg.sv
// Shared definitions for the digit-to-ASCII transmit path: frame state
// encoding, ASCII constants and the default digit count, which must match
// the upstream binary-to-decimal serializer.
package digit_ascii_tx_pkg;

  localparam int NUM_DIGITS_DEF = 6;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_BAD  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_EMIT    = 3'd2,
    S_TERM_CR = 3'd3,
    S_TERM_LF = 3'd4
  } state_t;

endpackage

// File: rtl/digit_ascii_tx_bcd_to_ascii.sv
// Combinational BCD digit to ASCII mapper. Values above 9 are not decimal
// digits and map to the BAD_CHAR substitute character instead.
module bcd_to_ascii
  import digit_ascii_tx_pkg::*;
#(
  parameter logic [7:0] BAD_CHAR = ASCII_BAD
) (
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  assign ascii = (digit > 4'd9) ? BAD_CHAR : (ASCII_ZERO | {4'h0, digit});

endmodule

// File: rtl/digit_ascii_tx.sv
// Captures one BCD digit burst from the serializer, then streams it to the
// UART as ASCII followed by CR LF over a valid/ready handshake.
// Build option: define DIGIT_ASCII_LZS_EN to suppress leading zeros (the
// last digit is always sent, so an all-zero frame still yields '0').
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for a rising edge of digit_sending
// S_CAPTURE | storing one digit per cycle until full or the burst ends
// S_EMIT    | presenting / skipping buffered digits, one per handshake
// S_TERM_CR | presenting the CR terminator
// S_TERM_LF | presenting the LF terminator; frame ends on its acceptance
module digit_ascii_tx
  import digit_ascii_tx_pkg::*;
#(
  parameter int         NUM_DIGITS = NUM_DIGITS_DEF,
  parameter logic [7:0] TERM_CR    = ASCII_CR,
  parameter logic [7:0] TERM_LF    = ASCII_LF,
  parameter logic [7:0] BAD_CHAR   = ASCII_BAD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_sending,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int            CW       = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state, state_nxt;
  logic [3:0]    dbuf [NUM_DIGITS];
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] idx, idx_nxt;
  logic [CW-1:0] sel_idx, last_idx, buf_waddr;
  logic [7:0]    tx_data_nxt, sel_ascii;
  logic [3:0]    sel_digit;
  logic          tx_valid_nxt, busy_nxt, overrun_nxt;
  logic          sending_q, trigger, buf_we, lzs_skip;

  assign trigger  = digit_sending & ~sending_q;
  assign last_idx = cnt - CNT_ONE;

  // Pick the buffered digit whose byte is loaded on this cycle: the next one
  // after an accepted byte, otherwise the current one (idx is 0 in CAPTURE).
  always_comb begin
    sel_idx = '0;
    if (state == S_EMIT) begin
      sel_idx = (tx_valid && tx_ready) ? (idx + CNT_ONE) : idx;
    end
  end

  assign sel_digit = (sel_idx < CNT_FULL) ? dbuf[sel_idx] : 4'h0;

  bcd_to_ascii #(
    .BAD_CHAR (BAD_CHAR)
  ) u_map (
    .digit (sel_digit),
    .ascii (sel_ascii)
  );

`ifdef DIGIT_ASCII_LZS_EN
  assign lzs_skip = (sel_digit == 4'h0) && (sel_idx != last_idx);
`else
  assign lzs_skip = 1'b0;
`endif

  // Next-state, buffer write and registered-output next values.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    busy_nxt     = busy;
    overrun_nxt  = trigger && (state != S_IDLE);
    buf_we       = 1'b0;
    buf_waddr    = cnt;

    case (state)
      S_IDLE: begin
        if (trigger) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          cnt_nxt   = CNT_ONE;
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (digit_sending && (cnt < CNT_FULL)) begin
          buf_we  = 1'b1;
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          // Full or burst ended early: decide on digit 0 right away so the
          // first byte appears one cycle after the last capture.
          state_nxt = S_EMIT;
          if (lzs_skip) begin
            idx_nxt = CNT_ONE;
          end else begin
            idx_nxt      = '0;
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = sel_ascii;
          end
        end
      end

      S_EMIT: begin
        if (tx_valid && tx_ready) begin
          if (idx == last_idx) begin
            tx_data_nxt = TERM_CR;
            state_nxt   = S_TERM_CR;
          end else begin
            idx_nxt     = idx + CNT_ONE;
            tx_data_nxt = sel_ascii;
          end
        end else if (!tx_valid) begin
          // Only reached while skipping leading zeros.
          if (lzs_skip) begin
            idx_nxt = idx + CNT_ONE;
          end else begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = sel_ascii;
          end
        end
      end

      S_TERM_CR: begin
        if (tx_ready) begin
          tx_data_nxt = TERM_LF;
          state_nxt   = S_TERM_LF;
        end
      end

      S_TERM_LF: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          busy_nxt     = 1'b0;
          cnt_nxt      = '0;
          idx_nxt      = '0;
          state_nxt    = S_IDLE;
        end
      end

      default: begin
        state_nxt    = S_IDLE;
        tx_valid_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  // State, counters, edge detector and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      sending_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      tx_data   <= tx_data_nxt;
      tx_valid  <= tx_valid_nxt;
      busy      <= busy_nxt;
      overrun   <= overrun_nxt;
      sending_q <= digit_sending;
    end
  end

  // Digit buffer, written during capture only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) dbuf[i] <= 4'h0;
    end else if (buf_we) begin
      dbuf[buf_waddr] <= digit_in;
    end
  end

endmodule

// File: tb/tb_digit_ascii_tx.sv
// Bench for digit_ascii_tx: directed and random digit bursts are checked
// against a queue model of the expected ASCII frame and its timing.
module tb_digit_ascii_tx;

  localparam int ND = 6;
`ifdef DIGIT_ASCII_LZS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_in;
  logic       digit_sending;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overrun;

  digit_ascii_tx dut (
    .clk           (clk),
    .rst           (rst),
    .digit_in      (digit_in),
    .digit_sending (digit_sending),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc_ctr = 0;
  int         ready_mode = 0;
  int         ovr_cnt = 0;
  int         lat = -1;
  int         lat_start = 0;
  logic       held = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic [3:0] burst [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: choose tx_ready, observe the registered outputs, advance.
  task automatic tick();
    cyc_ctr++;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (cyc_ctr % 3 == 0);
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
    if (held) begin
      chk("hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, held_data});
    end
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    held      = tx_valid && !tx_ready && !rst;
    held_data = tx_data;
    if (overrun) ovr_cnt++;
    @(negedge clk);
  endtask

  // Expected byte stream for the current burst; returns trigger-to-idle cycles
  // when tx_ready is always high.
  function automatic int build_exp();
    int n;
    int first;
    n = (burst.size() < ND) ? burst.size() : ND;
    first = 0;
    exp_q.delete();
    if (LZS) begin
      while (first < n - 1 && burst[first] == 4'h0) first++;
    end
    for (int i = first; i < n; i++) begin
      exp_q.push_back((burst[i] > 4'd9) ? 8'h3F : (8'h30 + {4'h0, burst[i]}));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    return n + 1 + first + exp_q.size();
  endfunction

  task automatic drive(input int extra);
    foreach (burst[i]) begin
      digit_sending = 1'b1;
      digit_in      = burst[i];
      tick();
    end
    for (int e = 0; e < extra; e++) begin
      digit_sending = 1'b1;
      digit_in      = 4'h0;
      tick();
    end
    digit_sending = 1'b0;
    digit_in      = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input string tag);
    lat = -1;
    for (int k = 0; k < 500; k++) begin
      if (!busy) begin
        lat = cyc_ctr + 1 - lat_start;
        break;
      end
      tick();
    end
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic compare(input string tag);
    int m;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_b%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic run_frame(input string tag, input int extra, input int mode);
    int exp_lat;
    ready_mode = mode;
    exp_lat    = build_exp();
    repeat (2) tick();
    got_q.delete();
    lat_start = cyc_ctr + 1;
    drive(extra);
    wait_done(tag);
    if (mode == 0) chk({tag, "_lat"}, lat, exp_lat);
    compare(tag);
  endtask

  initial begin
    rst           = 1'b1;
    digit_in      = 4'h0;
    digit_sending = 1'b0;
    tx_ready      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;

    burst = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    run_frame("seq", 0, 0);

    burst = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run_frame("zeros", 0, 0);

    ovr_cnt = 0;
    run_frame("zeros_trail", 2, 0);
    chk("trail_no_ovr", ovr_cnt, 0);

    burst = '{4'd0, 4'd6, 4'd5, 4'd5, 4'd3, 4'd5};
    run_frame("slow_ready", 0, 1);

    burst = '{4'd0, 4'd1, 4'hC, 4'd3, 4'd4, 4'd5};
    run_frame("bad_digit", 0, 0);

    burst = '{4'd7, 4'd0, 4'd9};
    run_frame("short", 0, 0);

    // Second burst while the first frame is still emitting.
    burst = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
    ready_mode = 1;
    void'(build_exp());
    repeat (2) tick();
    got_q.delete();
    ovr_cnt   = 0;
    lat_start = cyc_ctr + 1;
    drive(0);
    for (int k = 0; k < 20 && !tx_valid; k++) tick();
    chk("ovr_emit_started", {31'd0, tx_valid}, 32'd1);
    burst = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    drive(0);
    wait_done("ovr");
    chk("ovr_pulses", ovr_cnt, 1);
    compare("ovr");

    // Reset while a byte is waiting in EMIT.
    burst = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    ready_mode = 3;
    repeat (2) tick();
    drive(0);
    for (int k = 0; k < 20 && !tx_valid; k++) tick();
    chk("rst_mid_pre_valid", {31'd0, tx_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_data", {24'd0, tx_data}, 32'd0);
    burst = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2};
    run_frame("after_rst", 0, 0);

    for (int f = 0; f < 20; f++) begin
      int len;
      int r;
      burst.delete();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r < 35)      burst.push_back(4'h0);
        else if (r < 90) burst.push_back(4'($urandom_range(1, 9)));
        else             burst.push_back(4'($urandom_range(10, 15)));
      end
      run_frame($sformatf("rnd%0d", f), 0, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_ascii_tx.md
Name: digit_ascii_tx

Overview:
- Downstream neighbour of the binary-to-decimal digit serializer. That stage streams a fixed number of BCD digits, MSB first, one per clock, while its sending flag is high. It has no backpressure.
- This block captures one digit burst into a local buffer. It converts the digits to ASCII, appends a CR LF terminator, and hands the bytes one at a time to the UART transmitter through a valid/ready handshake.

Parameters:
- NUM_DIGITS, 6: digits captured per burst (MSB first). Samples beyond this in one burst are ignored.
- TERM_CR, 8'h0D: first terminator byte.
- TERM_LF, 8'h0A: second terminator byte.
- BAD_CHAR, 8'h3F: byte emitted for a digit value greater than 9.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- digit_in  in  4  BCD digit from the serializer.
- digit_sending  in  1  serializer burst flag. digit_in is valid every cycle this is high.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts tx_data this cycle.
- busy  out  1  high from the first captured digit until the LF byte is accepted.
- overrun  out  1  one-cycle pulse when a burst starts while the block is not in IDLE.

Behaviour:
- Interface is fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset: tx_data=0, tx_valid=0, busy=0, overrun=0. Digit buffer and counters clear; state goes to IDLE. Reset mid-burst or mid-emission abandons the frame; no partial bytes follow.
- Capture trigger: a rising edge of digit_sending, detected against a registered copy of the previous value.
- States:
  - IDLE: on the trigger cycle, store digit_in as buf[0], set cnt=1 and busy=1, go to CAPTURE.
  - CAPTURE: each cycle digit_sending=1 and cnt<NUM_DIGITS, store buf[cnt] and increment cnt. At cnt==NUM_DIGITS go to EMIT with idx=0. If digit_sending falls early, go to EMIT with only cnt digits valid.
  - EMIT: present the byte for buf[idx] ({4'h3,digit}, or BAD_CHAR if the digit >9). Advance idx on each accepted byte. After the last valid digit is accepted, go to TERM_CR.
  - TERM_CR: present TERM_CR; on acceptance go to TERM_LF.
  - TERM_LF: present TERM_LF; on acceptance clear busy, go to IDLE.
- Extra samples: samples while digit_sending stays high after NUM_DIGITS are ignored. The serializer may hold the flag one or two cycles longer with a trailing 0.
- Handshake:
  - A byte transfers on a cycle with tx_valid and tx_ready both high.
  - tx_valid and tx_data are registered and held stable until accepted.
  - tx_valid never drops without acceptance.
  - Back-to-back transfers are allowed: a new byte is presented the cycle after acceptance.
- Latency: first tx_valid rises 1 cycle after the last digit is captured. A 6-digit frame with tx_ready tied high takes 6+1+8 = 15 cycles from trigger to busy low (no suppression).
- Overrun: a rising edge of digit_sending while the state is not IDLE pulses overrun for one cycle. That burst is dropped entirely and the current frame is unaffected.
- Simultaneous events: a trigger on the same cycle the LF is accepted counts as overrun. IDLE is entered only on the following cycle.

Optional Feature:
- Macro: DIGIT_ASCII_LZS_EN.
- Defined: leading zeros are suppressed.
  - In EMIT, digits before the first nonzero digit are skipped without a handshake, at one cycle per skipped digit with tx_valid=0.
  - The last digit is always emitted, so an all-zero frame yields '0'.
  - A digit >9 counts as nonzero.
- Not defined: all captured digits are emitted, including leading zeros.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, CAPTURE, EMIT, TERM_CR, TERM_LF);
  - ASCII constants: ASCII_ZERO=8'h30, CR, LF, BAD_CHAR;
  - the default NUM_DIGITS, shared with the serializer's digit count.
- One natural sub-module: bcd_to_ascii, a combinational 4-bit digit to 8-bit ASCII mapper including the BAD_CHAR case. Everything else stays in one module.

Test Plan:
- Burst 0,1,2,3,4,5 with tx_ready=1, LZS on → bytes 31 32 33 34 35 0D 0A. With LZS off → 30 31 32 33 34 35 0D 0A. busy low after the LF transfer.
- Burst all zeros, LZS on → 30 0D 0A only. Same burst with 2 extra trailing cycles of digit_sending=1, digit 0 → identical output, no overrun.
- Burst 0,6,5,5,3,5 with tx_ready toggling 1-of-3 cycles → bytes 36 35 35 33 35 0D 0A. tx_data constant while tx_valid=1 and tx_ready=0.
- Second burst starts while emitting the first → overrun pulses for exactly 1 cycle. The first frame completes unchanged and no bytes from the second appear.
- Digit value 4'hC mid-burst, e.g. 0,1,C,3,4,5 → 31 3F 33 34 35 0D 0A.
- rst asserted while tx_valid=1 in EMIT → next cycle tx_valid=0, busy=0. A new burst 0,0,0,0,4,2 then yields 34 32 0D 0A (LZS on).
